// File: rtl/fp_unit_scheduler.sv
// Round-robin arbiter sharing one Floating_Point unit among N operand requesters.
// Latency: grant C0, unit inputs from C1, capture end of C(FP_LAT), rsp_valid pulse C(FP_LAT+1).
// Backpressure: req_ready only in IDLE; response is a single pulse with no backpressure.
module fp_unit_scheduler #(
    parameter int N      = 4,
    parameter int ID_W   = 2,
    parameter int FP_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [5*N-1:0]    req_int,
    input  logic [5*N-1:0]    req_man,
    output logic [N-1:0]      req_ready,
    output logic [4:0]        fp_integer_num,
    output logic [4:0]        fp_mantissa_num,
    input  logic [31:0]       fp_out,
    input  logic              fp_equality,
    input  logic              fp_balance,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [31:0]       rsp_out,
    output logic              rsp_equality,
    output logic              rsp_balance,
    output logic              busy
);

    localparam int CNT_W = (FP_LAT > 1) ? $clog2(FP_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   cur_id;
    logic [CNT_W-1:0]  cnt;

    logic [ID_W-1:0]   win;
    logic              win_vld;
    logic [ID_W-1:0]   idx;
    logic [N-1:0]      onehot;

    // Scan from the farthest offset down so the nearest valid request at or above ptr wins.
    always_comb begin
        win     = ptr;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % N);
            if (req_valid[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        onehot      = '0;
        onehot[win] = win_vld;
        req_ready   = (state == S_IDLE && !rst) ? onehot : '0;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            ptr             <= '0;
            cur_id          <= '0;
            cnt             <= '0;
            fp_integer_num  <= '0;
            fp_mantissa_num <= '0;
            rsp_valid       <= 1'b0;
            rsp_id          <= '0;
            rsp_out         <= '0;
            rsp_equality    <= 1'b0;
            rsp_balance     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        fp_integer_num  <= req_int[5*int'(win) +: 5];
                        fp_mantissa_num <= req_man[5*int'(win) +: 5];
                        cur_id          <= win;
                        ptr             <= (win == ID_W'(N - 1)) ? '0 : win + 1'b1;
                        cnt             <= CNT_W'(FP_LAT - 1);
                        state           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        rsp_out      <= fp_out;
                        rsp_equality <= fp_equality;
                        rsp_balance  <= fp_balance;
                        rsp_id       <= cur_id;
                        rsp_valid    <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_unit_scheduler.sv
// Directed bench for fp_unit_scheduler: FP_LAT=2 instance with a small unit model, FP_LAT=1 instance driven by hand.
module tb_fp_unit_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0]  a_req_valid, a_req_ready;
    logic [19:0] a_req_int, a_req_man;
    logic [4:0]  a_fp_int, a_fp_man;
    logic [31:0] a_fp_out;
    logic        a_fp_eq, a_fp_bal;
    logic        a_rsp_valid;
    logic [1:0]  a_rsp_id;
    logic [31:0] a_rsp_out;
    logic        a_rsp_eq, a_rsp_bal, a_busy;
    logic        a_auto;
    logic [31:0] a_force_out;
    logic        a_force_eq, a_force_bal;

    logic [3:0]  b_req_valid, b_req_ready;
    logic [19:0] b_req_int, b_req_man;
    logic [4:0]  b_fp_int, b_fp_man;
    logic [31:0] b_fp_out;
    logic        b_fp_eq, b_fp_bal;
    logic        b_rsp_valid;
    logic [1:0]  b_rsp_id;
    logic [31:0] b_rsp_out;
    logic        b_rsp_eq, b_rsp_bal, b_busy;

    // Unit model: out packs the operands as {int, man} bytes; can be overridden by the bench.
    always_comb begin
        if (a_auto) begin
            a_fp_out = {16'h0, 3'b0, a_fp_int, 3'b0, a_fp_man};
            a_fp_eq  = (a_fp_int == a_fp_man);
            a_fp_bal = ^a_fp_int;
        end else begin
            a_fp_out = a_force_out;
            a_fp_eq  = a_force_eq;
            a_fp_bal = a_force_bal;
        end
    end

    fp_unit_scheduler #(.N(4), .ID_W(2), .FP_LAT(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_int(a_req_int), .req_man(a_req_man), .req_ready(a_req_ready),
        .fp_integer_num(a_fp_int), .fp_mantissa_num(a_fp_man),
        .fp_out(a_fp_out), .fp_equality(a_fp_eq), .fp_balance(a_fp_bal),
        .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id), .rsp_out(a_rsp_out),
        .rsp_equality(a_rsp_eq), .rsp_balance(a_rsp_bal), .busy(a_busy)
    );

    fp_unit_scheduler #(.N(4), .ID_W(2), .FP_LAT(1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_int(b_req_int), .req_man(b_req_man), .req_ready(b_req_ready),
        .fp_integer_num(b_fp_int), .fp_mantissa_num(b_fp_man),
        .fp_out(b_fp_out), .fp_equality(b_fp_eq), .fp_balance(b_fp_bal),
        .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_out(b_rsp_out),
        .rsp_equality(b_rsp_eq), .rsp_balance(b_rsp_bal), .busy(b_busy)
    );

    task automatic test_reset;
        rst = 1'b1;
        a_req_valid = 4'b1111;
        b_req_valid = 4'b1111;
        @(negedge clk); #1;
        n_cmp++; if (a_req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", a_req_ready); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", a_busy); end
        n_cmp++; if ({a_fp_int, a_fp_man} !== 10'h0) begin n_bad++; $display("FAIL rst_fp_in: got %h want 0", {a_fp_int, a_fp_man}); end
        n_cmp++; if ({a_rsp_valid, a_rsp_id, a_rsp_out, a_rsp_eq, a_rsp_bal} !== 37'h0) begin n_bad++; $display("FAIL rst_rsp: got %h want 0", {a_rsp_valid, a_rsp_id, a_rsp_out, a_rsp_eq, a_rsp_bal}); end
        n_cmp++; if ({b_req_ready, b_busy, b_rsp_valid} !== 6'h0) begin n_bad++; $display("FAIL rst_b: got %h want 0", {b_req_ready, b_busy, b_rsp_valid}); end
        @(negedge clk);
        rst = 1'b0;
        a_req_valid = 4'b0000;
        b_req_valid = 4'b0000;
    endtask

    task automatic test_single;
        @(negedge clk);
        a_req_int[4:0] = 5'd13;
        a_req_man[4:0] = 5'd2;
        a_req_valid = 4'b0001;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0001) begin n_bad++; $display("FAIL t1_c0_ready: got %b want 0001", a_req_ready); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL t1_c0_busy: got %b want 0", a_busy); end
        @(negedge clk);
        a_req_valid = 4'b0000;
        a_auto = 1'b0;
        a_force_out = 32'hFFFF_FFFF;
        a_force_eq = 1'b1;
        a_force_bal = 1'b0;
        #1;
        n_cmp++; if (a_fp_int !== 5'd13 || a_fp_man !== 5'd2) begin n_bad++; $display("FAIL t1_c1_fp: got %0d/%0d want 13/2", a_fp_int, a_fp_man); end
        n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL t1_c1_busy: got %b want 1", a_busy); end
        @(negedge clk);
        a_force_out = 32'h0000_0D02;
        a_force_eq = 1'b0;
        a_force_bal = 1'b1;
        #1;
        n_cmp++; if (a_rsp_valid !== 1'b0 || a_busy !== 1'b1) begin n_bad++; $display("FAIL t1_c2: got valid=%b busy=%b want 0/1", a_rsp_valid, a_busy); end
        @(negedge clk); #1;
        n_cmp++; if (a_rsp_valid !== 1'b1 || a_rsp_id !== 2'd0) begin n_bad++; $display("FAIL t1_c3_rsp: got valid=%b id=%0d want 1/0", a_rsp_valid, a_rsp_id); end
        n_cmp++; if (a_rsp_out !== 32'h0000_0D02 || a_rsp_eq !== 1'b0 || a_rsp_bal !== 1'b1) begin n_bad++; $display("FAIL t1_c3_data: got %h eq=%b bal=%b want 00000d02/0/1", a_rsp_out, a_rsp_eq, a_rsp_bal); end
        n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL t1_c3_busy: got %b want 1", a_busy); end
        @(negedge clk); #1;
        n_cmp++; if (a_rsp_valid !== 1'b0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL t1_c4: got valid=%b busy=%b want 0/0", a_rsp_valid, a_busy); end
        n_cmp++; if (a_rsp_out !== 32'h0000_0D02 || a_fp_int !== 5'd13) begin n_bad++; $display("FAIL t1_c4_hold: got %h int=%0d want 00000d02/13", a_rsp_out, a_fp_int); end
        a_auto = 1'b1;
    endtask

    task automatic test_all_four;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_req_int[5*i +: 5] = 5'(4 + i);
            a_req_man[5*i +: 5] = 5'(8 + i);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) a_req_valid = 4'b1111;
            #1;
            n_cmp++; if (a_req_ready !== 4'(1 << k)) begin n_bad++; $display("FAIL t2_grant%0d: got %b want %b", k, a_req_ready, 4'(1 << k)); end
            @(negedge clk);
            a_req_valid[k] = 1'b0;
            #1;
            n_cmp++; if (a_fp_int !== 5'(4 + k) || a_fp_man !== 5'(8 + k)) begin n_bad++; $display("FAIL t2_fp%0d: got %0d/%0d want %0d/%0d", k, a_fp_int, a_fp_man, 4 + k, 8 + k); end
            n_cmp++; if (a_req_ready !== 4'b0000) begin n_bad++; $display("FAIL t2_wait_ready%0d: got %b want 0000", k, a_req_ready); end
            @(negedge clk); #1;
            n_cmp++; if (a_req_ready !== 4'b0000 || a_fp_int !== 5'(4 + k)) begin n_bad++; $display("FAIL t2_wait2_%0d: got ready=%b int=%0d want 0000/%0d", k, a_req_ready, a_fp_int, 4 + k); end
            @(negedge clk); #1;
            n_cmp++; if (a_rsp_valid !== 1'b1 || a_rsp_id !== 2'(k)) begin n_bad++; $display("FAIL t2_rsp%0d: got valid=%b id=%0d want 1/%0d", k, a_rsp_valid, a_rsp_id, k); end
            n_cmp++; if (a_rsp_out !== 32'((4 + k) * 256 + 8 + k) || a_rsp_bal !== ^(5'(4 + k))) begin n_bad++; $display("FAIL t2_data%0d: got %h bal=%b want %h", k, a_rsp_out, a_rsp_bal, 32'((4 + k) * 256 + 8 + k)); end
            n_cmp++; if (a_req_ready !== 4'b0000) begin n_bad++; $display("FAIL t2_done_ready%0d: got %b want 0000", k, a_req_ready); end
        end
    endtask

    task automatic test_no_starve;
        logic [3:0] exp_rdy;
        a_req_int[4:0] = 5'd1;
        a_req_int[14:10] = 5'd3;
        for (int k = 0; k < 6; k++) begin
            exp_rdy = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            @(negedge clk);
            if (k == 0) a_req_valid = 4'b0101;
            #1;
            n_cmp++; if (a_req_ready !== exp_rdy) begin n_bad++; $display("FAIL t3_grant%0d: got %b want %b", k, a_req_ready, exp_rdy); end
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            if (k == 5) a_req_valid = 4'b0000;
            #1;
            n_cmp++; if (a_rsp_valid !== 1'b1 || a_rsp_id !== ((k % 2 == 0) ? 2'd0 : 2'd2)) begin n_bad++; $display("FAIL t3_rsp%0d: got valid=%b id=%0d", k, a_rsp_valid, a_rsp_id); end
        end
    endtask

    task automatic test_late_arrival;
        @(negedge clk);
        a_req_int[4:0] = 5'd9;
        a_req_man[4:0] = 5'd9;
        a_req_valid = 4'b0001;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0001) begin n_bad++; $display("FAIL t4_grant0: got %b want 0001", a_req_ready); end
        @(negedge clk);
        a_req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        a_req_int[19:15] = 5'd30;
        a_req_man[19:15] = 5'd1;
        a_req_valid = 4'b1000;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0000) begin n_bad++; $display("FAIL t4_done_ready: got %b want 0000", a_req_ready); end
        n_cmp++; if (a_rsp_valid !== 1'b1 || a_rsp_out !== 32'h0000_0909 || a_rsp_eq !== 1'b1 || a_rsp_bal !== 1'b0) begin n_bad++; $display("FAIL t4_rsp0: got v=%b %h eq=%b bal=%b want 1/00000909/1/0", a_rsp_valid, a_rsp_out, a_rsp_eq, a_rsp_bal); end
        @(negedge clk); #1;
        n_cmp++; if (a_req_ready !== 4'b1000 || a_busy !== 1'b0) begin n_bad++; $display("FAIL t4_idle_grant3: got ready=%b busy=%b want 1000/0", a_req_ready, a_busy); end
        @(negedge clk);
        a_req_valid = 4'b0000;
        #1;
        n_cmp++; if (a_fp_int !== 5'd30 || a_fp_man !== 5'd1) begin n_bad++; $display("FAIL t4_fp3: got %0d/%0d want 30/1", a_fp_int, a_fp_man); end
        @(negedge clk);
        @(negedge clk); #1;
        n_cmp++; if (a_rsp_valid !== 1'b1 || a_rsp_id !== 2'd3 || a_rsp_out !== 32'h0000_1E01) begin n_bad++; $display("FAIL t4_rsp3: got v=%b id=%0d %h want 1/3/00001e01", a_rsp_valid, a_rsp_id, a_rsp_out); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        a_req_int[14:10] = 5'd21;
        a_req_man[14:10] = 5'd3;
        a_req_int[9:5] = 5'd17;
        a_req_man[9:5] = 5'd6;
        a_req_valid = 4'b0100;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0100) begin n_bad++; $display("FAIL t5_grant2: got %b want 0100", a_req_ready); end
        @(negedge clk);
        a_req_valid = 4'b0000;
        #1;
        n_cmp++; if (a_fp_int !== 5'd21 || a_busy !== 1'b1) begin n_bad++; $display("FAIL t5_c1: got int=%0d busy=%b want 21/1", a_fp_int, a_busy); end
        @(negedge clk);
        rst = 1'b1;
        a_req_valid = 4'b1010;
        #1;
        n_cmp++; if ({a_fp_int, a_fp_man} !== 10'h0 || a_busy !== 1'b0 || a_req_ready !== 4'b0000) begin n_bad++; $display("FAIL t5_abort: got fp=%h busy=%b ready=%b want 0/0/0000", {a_fp_int, a_fp_man}, a_busy, a_req_ready); end
        n_cmp++; if (a_rsp_valid !== 1'b0 || a_rsp_out !== 32'h0 || a_rsp_id !== 2'd0) begin n_bad++; $display("FAIL t5_abort_rsp: got v=%b %h id=%0d want 0/0/0", a_rsp_valid, a_rsp_out, a_rsp_id); end
        @(negedge clk); #1;
        n_cmp++; if (a_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t5_no_pulse: got %b want 0", a_rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0010) begin n_bad++; $display("FAIL t5_ptr0: got %b want 0010", a_req_ready); end
        @(negedge clk);
        a_req_valid = 4'b0000;
        #1;
        n_cmp++; if (a_fp_int !== 5'd17 || a_fp_man !== 5'd6) begin n_bad++; $display("FAIL t5_fp1: got %0d/%0d want 17/6", a_fp_int, a_fp_man); end
        @(negedge clk);
        @(negedge clk); #1;
        n_cmp++; if (a_rsp_valid !== 1'b1 || a_rsp_id !== 2'd1 || a_rsp_out !== 32'h0000_1106) begin n_bad++; $display("FAIL t5_rsp1: got v=%b id=%0d %h want 1/1/00001106", a_rsp_valid, a_rsp_id, a_rsp_out); end
    endtask

    task automatic test_lat1;
        @(negedge clk);
        b_req_int[14:10] = 5'd7;
        b_req_man[14:10] = 5'd9;
        b_req_int[19:15] = 5'd12;
        b_req_man[19:15] = 5'd4;
        b_req_valid = 4'b1100;
        b_fp_out = 32'hDEAD_0000;
        #1;
        n_cmp++; if (b_req_ready !== 4'b0100) begin n_bad++; $display("FAIL t6_grant2: got %b want 0100", b_req_ready); end
        @(negedge clk);
        b_fp_out = 32'h1111_1111;
        #1;
        n_cmp++; if (b_fp_int !== 5'd7 || b_fp_man !== 5'd9 || b_busy !== 1'b1 || b_req_ready !== 4'b0000) begin n_bad++; $display("FAIL t6_c1: got %0d/%0d busy=%b ready=%b want 7/9/1/0000", b_fp_int, b_fp_man, b_busy, b_req_ready); end
        #2;
        b_fp_out = 32'hCAFE_F00D;
        b_fp_eq = 1'b1;
        b_fp_bal = 1'b0;
        @(negedge clk);
        b_req_valid = 4'b1000;
        b_fp_out = 32'h0BAD_0BAD;
        #1;
        n_cmp++; if (b_rsp_valid !== 1'b1 || b_rsp_id !== 2'd2 || b_rsp_out !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL t6_rsp2: got v=%b id=%0d %h want 1/2/cafef00d", b_rsp_valid, b_rsp_id, b_rsp_out); end
        n_cmp++; if (b_rsp_eq !== 1'b1 || b_rsp_bal !== 1'b0 || b_req_ready !== 4'b0000) begin n_bad++; $display("FAIL t6_rsp2_flags: got eq=%b bal=%b ready=%b want 1/0/0000", b_rsp_eq, b_rsp_bal, b_req_ready); end
        @(negedge clk); #1;
        n_cmp++; if (b_req_ready !== 4'b1000 || b_rsp_valid !== 1'b0 || b_busy !== 1'b0) begin n_bad++; $display("FAIL t6_c3: got ready=%b v=%b busy=%b want 1000/0/0", b_req_ready, b_rsp_valid, b_busy); end
        n_cmp++; if (b_rsp_out !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL t6_hold: got %h want cafef00d", b_rsp_out); end
        @(negedge clk);
        b_req_valid = 4'b0000;
        b_fp_out = 32'h0000_0003;
        b_fp_bal = 1'b1;
        #1;
        n_cmp++; if (b_fp_int !== 5'd12 || b_fp_man !== 5'd4) begin n_bad++; $display("FAIL t6_fp3: got %0d/%0d want 12/4", b_fp_int, b_fp_man); end
        @(negedge clk); #1;
        n_cmp++; if (b_rsp_valid !== 1'b1 || b_rsp_id !== 2'd3 || b_rsp_out !== 32'h3 || b_rsp_bal !== 1'b1) begin n_bad++; $display("FAIL t6_rsp3: got v=%b id=%0d %h bal=%b want 1/3/3/1", b_rsp_valid, b_rsp_id, b_rsp_out, b_rsp_bal); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_req_valid = '0; a_req_int = '0; a_req_man = '0;
        a_auto = 1'b1; a_force_out = '0; a_force_eq = 1'b0; a_force_bal = 1'b0;
        b_req_valid = '0; b_req_int = '0; b_req_man = '0;
        b_fp_out = '0; b_fp_eq = 1'b0; b_fp_bal = 1'b0;
        test_reset;
        test_single;
        test_all_four;
        test_no_starve;
        test_late_arrival;
        test_reset_mid;
        test_lat1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
